bcd_mod_counter: RTL and testbench

//   Parametrised cascaded BCD counter, DIGITS decimal digits, counting modulo MODULUS.

---
 rtl/bcd_mod_counter.sv | 96 +++++++++
 tb/tb_bcd_mod_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// Cascaded BCD counter, DIGITS decimal digits, counting modulo MODULUS.
// Up/down stepping with ripple carry/borrow, sync clear, validated parallel load, wrap pulse.
module bcd_mod_counter #(
  parameter int DIGITS  = 3,
  parameter int MODULUS = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                tick,
  input  logic                up,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                wrap,
  output logic                load_err
);
  localparam int W = 4*DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    int r;
    to_bcd = '0;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      to_bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  if (DIGITS < 1 || MODULUS < 2 || MODULUS > 10**DIGITS) begin : g_bad_param
    $fatal(1, "bcd_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 10**DIGITS");
  end

  logic [W-1:0]      count_q, count_d, step_val;
  logic              wrap_q, wrap_d, err_q, err_d;
  logic [DIGITS-1:0] term, carry, dig_ok;
  logic              at_end, load_ok;

  // term: digit sits at its roll-over value (9 going up, 0 going down)
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [3:0] d;
    assign d         = count_q[4*g +: 4];
    assign term[g]   = up ? (d == 4'd9) : (d == 4'd0);
    assign dig_ok[g] = (load_val[4*g +: 4] <= 4'd9);
    assign step_val[4*g +: 4] = !carry[g] ? d :
                                term[g]   ? (up ? 4'd0 : 4'd9) :
                                            (up ? d + 4'd1 : d - 4'd1);
    if (g == 0) begin : g_c0
      assign carry[g] = 1'b1;
    end else begin : g_cn
      assign carry[g] = carry[g-1] & term[g-1];
    end
  end

  // With all digits valid, BCD magnitude order equals plain unsigned order.
  assign at_end  = up ? (count_q == MAX_BCD) : (&term);
  assign load_ok = (&dig_ok) && (load_val <= MAX_BCD);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (load_ok) count_d = load_val;
      else         err_d   = 1'b1;
    end else if (en && tick) begin
      if (at_end) begin
        count_d = up ? '0 : MAX_BCD;
        wrap_d  = 1'b1;
      end else begin
        count_d = step_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;
endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench: 3-digit mod-1000 instance (A) and 2-digit mod-60 instance (B).
module tb_bcd_mod_counter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        a_en, a_tick, a_up, a_clr, a_load, a_wrap, a_err;
  logic [11:0] a_lv, a_cnt;
  logic        b_en, b_tick, b_up, b_clr, b_load, b_wrap, b_err;
  logic [7:0]  b_lv, b_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_mod_counter #(.DIGITS(3), .MODULUS(1000)) u_a (
    .clk(clk), .reset(reset), .en(a_en), .tick(a_tick), .up(a_up), .clr(a_clr),
    .load(a_load), .load_val(a_lv), .count(a_cnt), .wrap(a_wrap), .load_err(a_err));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_b (
    .clk(clk), .reset(reset), .en(b_en), .tick(b_tick), .up(b_up), .clr(b_clr),
    .load(b_load), .load_val(b_lv), .count(b_cnt), .wrap(b_wrap), .load_err(b_err));

  function automatic logic [11:0] bcd3(input int v);
    logic [3:0] h, t, o;
    h = 4'((v / 100) % 10);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic clk_step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string nm, input logic [7:0] c, input logic w, input logic e);
    n_cmp++;
    if (b_cnt !== c || b_wrap !== w || b_err !== e) begin
      n_bad++;
      $display("FAIL %s: got count=%h wrap=%b load_err=%b, want count=%h wrap=%b load_err=%b",
               nm, b_cnt, b_wrap, b_err, c, w, e);
    end
  endtask

  task automatic test_reset;
    {a_en, a_tick, a_up, a_clr, a_load} = '0; a_lv = '0;
    {b_en, b_tick, b_up, b_clr, b_load} = '0; b_lv = '0;
    #3;
    n_cmp++;
    if (a_cnt !== 12'h000 || a_wrap !== 1'b0 || a_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_a: got %h/%b/%b want 000/0/0", a_cnt, a_wrap, a_err);
    end
    chk_b("reset_b", 8'h00, 1'b0, 1'b0);
    @(negedge clk) reset = 1'b1;
    clk_step;
    n_cmp++;
    if (a_cnt !== 12'h000) begin n_bad++; $display("FAIL reset_hold: got %h want 000", a_cnt); end
    a_load = 1'b1; a_lv = 12'h457;
    clk_step;
    a_load = 1'b0;
    n_cmp++;
    if (a_cnt !== 12'h457) begin n_bad++; $display("FAIL load_457: got %h want 457", a_cnt); end
    a_en = 1'b1; a_tick = 1'b1; a_up = 1'b1;
    clk_step;
    n_cmp++;
    if (a_cnt !== 12'h458) begin n_bad++; $display("FAIL step_458: got %h want 458", a_cnt); end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (a_cnt !== 12'h000 || a_wrap !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got %h/%b want 000/0", a_cnt, a_wrap);
    end
    a_en = 1'b0; a_tick = 1'b0;
    @(negedge clk) reset = 1'b1;
    clk_step;
  endtask

  task automatic test_up_wrap;
    a_en = 1'b1; a_tick = 1'b1; a_up = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      clk_step;
      n_cmp++;
      if (a_cnt !== bcd3(i % 1000) || a_wrap !== (i == 1000)) begin
        n_bad++;
        $display("FAIL up_step%0d: got %h/%b want %h/%b", i, a_cnt, a_wrap, bcd3(i % 1000), (i == 1000));
      end
      if (i == 10) begin
        n_cmp++;
        if (a_cnt !== 12'h010) begin n_bad++; $display("FAIL carry_010: got %h want 010", a_cnt); end
      end
      if (i == 100) begin
        n_cmp++;
        if (a_cnt !== 12'h100) begin n_bad++; $display("FAIL carry_100: got %h want 100", a_cnt); end
      end
    end
    clk_step;
    n_cmp++;
    if (a_cnt !== 12'h001 || a_wrap !== 1'b0) begin
      n_bad++; $display("FAIL after_wrap: got %h/%b want 001/0", a_cnt, a_wrap);
    end
    a_en = 1'b0;
  endtask

  task automatic test_down_mode;
    b_load = 1'b1; b_lv = 8'h01;
    clk_step;
    b_load = 1'b0;
    chk_b("dn_load01", 8'h01, 1'b0, 1'b0);
    b_en = 1'b1; b_tick = 1'b1; b_up = 1'b0;
    clk_step; chk_b("dn_00", 8'h00, 1'b0, 1'b0);
    clk_step; chk_b("dn_wrap59", 8'h59, 1'b1, 1'b0);
    b_up = 1'b1;
    clk_step; chk_b("mode_up_wrap", 8'h00, 1'b1, 1'b0);
    b_en = 1'b0;
    clk_step; chk_b("mode_hold", 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_borrow;
    b_load = 1'b1; b_lv = 8'h50;
    clk_step;
    b_load = 1'b0; b_en = 1'b1; b_tick = 1'b1; b_up = 1'b0;
    clk_step; chk_b("borrow_49", 8'h49, 1'b0, 1'b0);
    b_en = 1'b0; b_load = 1'b1; b_lv = 8'h10;
    clk_step;
    b_load = 1'b0; b_en = 1'b1;
    clk_step; chk_b("borrow_09", 8'h09, 1'b0, 1'b0);
    b_en = 1'b0; b_tick = 1'b0; b_up = 1'b1;
  endtask

  task automatic test_load_checks;
    b_load = 1'b1; b_lv = 8'h5A;
    clk_step; chk_b("load_5A_rej", 8'h09, 1'b0, 1'b1);
    b_load = 1'b0;
    clk_step; chk_b("load_err_1cyc", 8'h09, 1'b0, 1'b0);
    b_load = 1'b1; b_lv = 8'h60;
    clk_step; chk_b("load_60_rej", 8'h09, 1'b0, 1'b1);
    b_lv = 8'h59;
    clk_step; chk_b("load_59_ok", 8'h59, 1'b0, 1'b0);
    b_load = 1'b0;
  endtask

  task automatic test_priority;
    b_clr = 1'b1; b_load = 1'b1; b_lv = 8'h23; b_en = 1'b1; b_tick = 1'b1; b_up = 1'b1;
    clk_step; chk_b("prio_clr", 8'h00, 1'b0, 1'b0);
    b_lv = 8'h7F;
    clk_step; chk_b("prio_clr_badload", 8'h00, 1'b0, 1'b0);
    b_clr = 1'b0; b_lv = 8'h23;
    clk_step; chk_b("prio_load_nostep", 8'h23, 1'b0, 1'b0);
    b_lv = 8'h7F;
    clk_step; chk_b("prio_rej_nostep", 8'h23, 1'b0, 1'b1);
    b_load = 1'b0; b_en = 1'b0; b_tick = 1'b0;
  endtask

  task automatic test_gating;
    logic [7:0] exp_g [9];
    exp_g = '{8'h24, 8'h24, 8'h24, 8'h25, 8'h25, 8'h25, 8'h26, 8'h26, 8'h26};
    b_en = 1'b0; b_tick = 1'b1; b_up = 1'b1;
    for (int k = 0; k < 10; k++) begin
      clk_step; chk_b("gate_en0", 8'h23, 1'b0, 1'b0);
    end
    b_en = 1'b1; b_tick = 1'b0;
    clk_step; chk_b("gate_tick0", 8'h23, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      b_tick = (k % 3 == 0);
      clk_step; chk_b("gate_tick3", exp_g[k], 1'b0, 1'b0);
    end
    b_en = 1'b0; b_tick = 1'b0;
  endtask

  task automatic test_back_to_back;
    b_load = 1'b1; b_lv = 8'h58;
    clk_step;
    b_load = 1'b0; b_en = 1'b1; b_tick = 1'b1; b_up = 1'b1;
    clk_step; chk_b("b2b_59", 8'h59, 1'b0, 1'b0);
    clk_step; chk_b("b2b_wrap", 8'h00, 1'b1, 1'b0);
    clk_step; chk_b("b2b_01", 8'h01, 1'b0, 1'b0);
    b_en = 1'b0; b_tick = 1'b0;
  endtask

  initial begin
    test_reset;
    test_up_wrap;
    test_down_mode;
    test_borrow;
    test_load_checks;
    test_priority;
    test_gating;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
